// File: rtl/i3c_hdr_pattern_pkg.sv
// i3c_hdr_pattern_pkg: shared states, pattern types and pad-drive map for HDR Exit/Restart generation
package i3c_hdr_pattern_pkg;
  typedef enum logic [2:0] {IDLE, PRE, TOG_LO, TOG_HI, STOP_SETUP, STOP, RS_SCL} state_e;
  typedef enum logic {PAT_EXIT, PAT_RESTART} pat_e;
  localparam logic [2:0] EXIT_FALL_EDGES = 3'd4;
  localparam logic [2:0] RESTART_FALL_EDGES = 3'd2;
  // Pad drive per state as {scl, sda, sda_en}
  function automatic logic [2:0] drive(state_e s);
    case (s)
      PRE:        return 3'b011;
      TOG_LO:     return 3'b001;
      TOG_HI:     return 3'b011;
      STOP_SETUP: return 3'b101;
      STOP:       return 3'b111;
      RS_SCL:     return 3'b111;
      default:    return 3'b110;
    endcase
  endfunction
endpackage

// File: rtl/hdr_phase_timer.sv
// hdr_phase_timer: phase down-counter, reloads on load and flags the last cycle of a phase
module hdr_phase_timer #(
  parameter int PHASE_CYCLES = 2,
  parameter int PHASE_W = $clog2(PHASE_CYCLES + 1)
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst,
  input  logic load,
  output logic phase_end
);
  logic [PHASE_W-1:0] cnt;
  always_ff @(posedge i_sys_clk or negedge i_sys_rst)
    if (!i_sys_rst) cnt <= '0;
    else if (load) cnt <= PHASE_W'(PHASE_CYCLES - 1);
    else if (cnt != '0) cnt <= cnt - PHASE_W'(1);
  assign phase_end = cnt == '0;
endmodule

// File: rtl/hdr_exit_pattern_gen.sv
// hdr_exit_pattern_gen: drives the I3C HDR Exit / HDR Restart SDA toggle patterns with SCL held low
module hdr_exit_pattern_gen
  import i3c_hdr_pattern_pkg::*;
#(
  parameter int PHASE_CYCLES = 2,
  parameter int PHASE_W = $clog2(PHASE_CYCLES + 1)
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst,
  input  logic i_exit_req,
  input  logic i_restart_req,
  output logic o_busy,
  output logic o_done,
  output logic o_scl,
  output logic o_sda,
  output logic o_sda_en
);
  state_e state, nxt;
  pat_e pat;
  logic [2:0] fe;
  logic phase_end, accept;
  logic [2:0] fe_tgt;
  assign accept = state == IDLE && (i_exit_req || i_restart_req);
  assign fe_tgt = pat == PAT_EXIT ? EXIT_FALL_EDGES : RESTART_FALL_EDGES;
  hdr_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES), .PHASE_W(PHASE_W)) u_timer (
    .i_sys_clk(i_sys_clk),
    .i_sys_rst(i_sys_rst),
    .load(state == IDLE ? accept : phase_end),
    .phase_end(phase_end)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = accept ? PRE : IDLE;
      PRE:        nxt = phase_end ? TOG_LO : PRE;
      TOG_LO:     nxt = !phase_end ? TOG_LO : (pat == PAT_EXIT && fe == fe_tgt) ? STOP_SETUP : TOG_HI;
      TOG_HI:     nxt = !phase_end ? TOG_HI : (pat == PAT_RESTART && fe == fe_tgt) ? RS_SCL : TOG_LO;
      STOP_SETUP: nxt = phase_end ? STOP : STOP_SETUP;
      STOP:       nxt = phase_end ? IDLE : STOP;
      RS_SCL:     nxt = phase_end ? IDLE : RS_SCL;
      default:    nxt = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they change on the same edge as the state
  always_ff @(posedge i_sys_clk or negedge i_sys_rst)
    if (!i_sys_rst) begin
      state <= IDLE;
      pat <= PAT_EXIT;
      fe <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      {o_scl, o_sda, o_sda_en} <= 3'b110;
    end else begin
      state <= nxt;
      o_busy <= nxt != IDLE;
      o_done <= state != IDLE && nxt == IDLE;
      {o_scl, o_sda, o_sda_en} <= drive(nxt);
      if (accept) begin
        pat <= i_exit_req ? PAT_EXIT : PAT_RESTART;
        fe <= '0;
      end else if (nxt == TOG_LO && state != TOG_LO) fe <= fe + 3'd1;
    end
endmodule

// File: tb/tb_hdr_exit_pattern_gen.sv
// tb_hdr_exit_pattern_gen: randomized check of two generator instances (PHASE_CYCLES 2 and 1) against a phase-list model
module tb_hdr_exit_pattern_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] ex = '0, rs = '0;
  logic [1:0] busy, done, scl, sda, en;
  int tests = 0, fails = 0;
  logic [2:0] exp_q[$];
  localparam logic [4:0] IDLE_V = 5'b00110;
  localparam logic [4:0] DONE_V = 5'b01110;

  hdr_exit_pattern_gen #(.PHASE_CYCLES(2)) u_p2 (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_exit_req(ex[0]), .i_restart_req(rs[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_scl(scl[0]), .o_sda(sda[0]), .o_sda_en(en[0])
  );
  hdr_exit_pattern_gen #(.PHASE_CYCLES(1)) u_p1 (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_exit_req(ex[1]), .i_restart_req(rs[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_scl(scl[1]), .o_sda(sda[1]), .o_sda_en(en[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // {busy, done, scl, sda as seen on the wire, sda_en}
  function automatic logic [4:0] obs(input int i);
    return {busy[i], done[i], scl[i], en[i] ? sda[i] : 1'b1, en[i]};
  endfunction

  // Pattern as a list of {scl,sda,en} phases: PRE, n SDA falls with SCL low, then the ending
  function automatic void build(input int p, input bit exit_pat);
    logic [2:0] ph[$];
    int n = exit_pat ? 4 : 2;
    ph.push_back(3'b011);
    for (int f = 1; f <= n; f++) begin
      ph.push_back(3'b001);
      if (f < n || !exit_pat) ph.push_back(3'b011);
    end
    if (exit_pat) begin
      ph.push_back(3'b101);
      ph.push_back(3'b111);
    end else ph.push_back(3'b111);
    exp_q.delete();
    foreach (ph[k]) for (int c = 0; c < p; c++) exp_q.push_back(ph[k]);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_p2", obs(0), IDLE_V);
      check("idle_p1", obs(1), IDLE_V);
    end
  endtask

  // kind: 0 exit, 1 restart, 2 both; starts at a negedge, ends at the negedge showing o_done
  task automatic run(input int i, input int kind, input bit noise, input int extra_at);
    int falls = 0;
    logic prev = 1'b1;
    logic [4:0] o;
    build(i == 0 ? 2 : 1, kind != 1);
    ex[i] = kind != 1;
    rs[i] = kind != 0;
    foreach (exp_q[j]) begin
      @(negedge clk);
      ex[i] = 1'b0;
      rs[i] = 1'b0;
      if (noise) begin
        ex[i] = 1'($urandom_range(0, 1));
        rs[i] = 1'($urandom_range(0, 1));
      end
      if (j == extra_at) rs[i] = 1'b1;
      o = obs(i);
      check($sformatf("pat_i%0d_k%0d_c%0d", i, kind, j), o, {2'b10, exp_q[j]});
      if (!o[2] && prev && !o[1]) falls++;
      prev = o[1];
    end
    @(negedge clk);
    ex[i] = 1'b0;
    rs[i] = 1'b0;
    check($sformatf("done_i%0d_k%0d", i, kind), obs(i), DONE_V);
    check($sformatf("falls_i%0d_k%0d", i, kind), 8'(falls), kind != 1 ? 8'd4 : 8'd2);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_p2", obs(0), IDLE_V);
    check("reset_p1", obs(1), IDLE_V);
    rst = 1'b1;
    idle(20);
    run(0, 0, 1'b0, -1);
    idle(2);
    run(0, 1, 1'b0, -1);
    idle(2);
    run(0, 2, 1'b0, 5);
    idle(3);
    ex[0] = 1'b1;
    repeat (9) begin
      @(negedge clk);
      ex[0] = 1'b0;
    end
    check("mid_busy", obs(0), {2'b10, 3'b011});
    #2 rst = 1'b0;
    #1 check("async_rst_p2", obs(0), IDLE_V);
    check("async_rst_p1", obs(1), IDLE_V);
    @(negedge clk);
    check("in_rst", obs(0), IDLE_V);
    rst = 1'b1;
    run(0, 0, 1'b0, -1);
    idle(2);
    run(1, 0, 1'b0, -1);
    run(1, 0, 1'b0, -1);
    idle(2);
    repeat (24) begin
      run($urandom_range(0, 1), $urandom_range(0, 2), 1'b1, -1);
      idle($urandom_range(0, 3));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
